// File: rtl/wb_arb.sv
// Register-file write-port arbiter: merges in-order pipeline writes with
// long-latency unit results buffered in a 2-entry FIFO, with WAW kill and starvation stall.
module wb_arb #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        stall_req
);

  localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

  // Slot 0 is always the oldest live entry; slot 1 is only valid when slot 0 is.
  logic [1:0]  v_r;
  logic [4:0]  a_r [2];
  logic [31:0] d_r [2];
  logic [7:0]  cnt_r;
  logic        stall_r;
  logic        we_r;
  logic [4:0]  waddr_r;
  logic [31:0] wdata_r;

  logic        pipe_sel_s;
  logic        push_s;
  logic        pop_s;
  logic        lu_ready_s;
  logic [1:0]  keep_s;
  logic [1:0]  c_v_s;
  logic [4:0]  c_a_s [2];
  logic [31:0] c_d_s [2];
  logic [1:0]  n_v_s;
  logic [4:0]  n_a_s [2];
  logic [31:0] n_d_s [2];

  assign lu_ready_s = !(v_r[0] && v_r[1]);
  assign lu_ready   = lu_ready_s;
  assign we         = we_r;
  assign waddr      = waddr_r;
  assign wdata      = wdata_r;
  assign stall_req  = stall_r;

  // Select the write source, apply WAW kills, compact, pop and append.
  always_comb begin
    pipe_sel_s = pipe_we && (pipe_waddr != 5'd0);
    push_s     = lu_valid && lu_ready_s && (lu_waddr != 5'd0);
    for (int i = 0; i < 2; i++) begin
      keep_s[i] = v_r[i] && !(pipe_sel_s && (a_r[i] == pipe_waddr));
    end

    c_a_s = a_r;
    c_d_s = d_r;
    if (keep_s[0]) begin
      c_v_s = {keep_s[1], 1'b1};
    end else if (keep_s[1]) begin
      c_v_s    = 2'b01;
      c_a_s[0] = a_r[1];
      c_d_s[0] = d_r[1];
    end else begin
      c_v_s = 2'b00;
    end

    // A drain slot exists only when the pipeline is not writing.
    pop_s = !pipe_sel_s && c_v_s[0];

    n_a_s = c_a_s;
    n_d_s = c_d_s;
    if (pop_s) begin
      n_v_s    = {1'b0, c_v_s[1]};
      n_a_s[0] = c_a_s[1];
      n_d_s[0] = c_d_s[1];
    end else begin
      n_v_s = c_v_s;
    end

    case ({push_s, n_v_s[0]})
      2'b10: begin
        n_v_s[0] = 1'b1;
        n_a_s[0] = lu_waddr;
        n_d_s[0] = lu_wdata;
      end
      2'b11: begin
        n_v_s[1] = 1'b1;
        n_a_s[1] = lu_waddr;
        n_d_s[1] = lu_wdata;
      end
      default: begin
        n_v_s[1] = n_v_s[1];
      end
    endcase
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_r    <= 2'b00;
      a_r[0] <= 5'd0;
      a_r[1] <= 5'd0;
      d_r[0] <= 32'd0;
      d_r[1] <= 32'd0;
    end else begin
      v_r <= n_v_s;
      a_r <= n_a_s;
      d_r <= n_d_s;
    end
  end

  // Starvation counter and the stall request it raises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= 8'd0;
      stall_r <= 1'b0;
    end else begin
      if (pop_s || (n_v_s == 2'b00)) begin
        cnt_r   <= 8'd0;
        stall_r <= 1'b0;
      end else begin
        if (v_r[0] && (cnt_r != LIMIT_C)) begin
          cnt_r <= cnt_r + 8'd1;
        end else begin
          cnt_r <= cnt_r;
        end
        if (cnt_r == LIMIT_C) begin
          stall_r <= 1'b1;
        end else begin
          stall_r <= stall_r;
        end
      end
    end
  end

  // Registered register-file write port; address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r    <= 1'b0;
      waddr_r <= 5'd0;
      wdata_r <= 32'd0;
    end else begin
      we_r <= pipe_sel_s || pop_s;
      if (pipe_sel_s) begin
        waddr_r <= pipe_waddr;
        wdata_r <= pipe_wdata;
      end else if (pop_s) begin
        waddr_r <= c_a_s[0];
        wdata_r <= c_d_s[0];
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
      end
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// Self-checking bench for wb_arb: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_wb_arb;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [4:0]  q_a [$];
  logic [31:0] q_d [$];
  int          m_cnt;
  logic        m_stall;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  wb_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .lu_ready(lu_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q_a.delete();
    q_d.delete();
    m_cnt   = 0;
    m_stall = 1'b0;
    m_we    = 1'b0;
    m_waddr = 5'd0;
    m_wdata = 32'd0;
  endtask

  // One clock edge of the arbiter's behaviour, from the written rules.
  task automatic model_edge();
    bit sel, ready, popped, was_busy;
    sel      = pipe_we && (pipe_waddr != 5'd0);
    ready    = (q_a.size() < 2);
    was_busy = (q_a.size() > 0);
    popped   = 1'b0;
    if (sel) begin
      for (int i = q_a.size() - 1; i >= 0; i--) begin
        if (q_a[i] == pipe_waddr) begin
          q_a.delete(i);
          q_d.delete(i);
        end
      end
      m_we = 1'b1; m_waddr = pipe_waddr; m_wdata = pipe_wdata;
    end else if (q_a.size() > 0) begin
      m_we = 1'b1; m_waddr = q_a.pop_front(); m_wdata = q_d.pop_front();
      popped = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (lu_valid && ready && (lu_waddr != 5'd0)) begin
      q_a.push_back(lu_waddr);
      q_d.push_back(lu_wdata);
    end
    if (popped || q_a.size() == 0) begin
      m_stall = 1'b0;
      m_cnt   = 0;
    end else begin
      if (m_cnt == LIMIT) m_stall = 1'b1;
      if (was_busy && m_cnt < LIMIT) m_cnt++;
    end
  endtask

  task automatic step(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld);
    @(negedge clk);
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
    #1 chk("lu_ready", {31'd0, lu_ready}, {31'd0, (q_a.size() < 2)});
    @(posedge clk);
    model_edge();
    #1;
    chk("we", {31'd0, we}, {31'd0, m_we});
    chk("waddr", {27'd0, waddr}, {27'd0, m_waddr});
    chk("wdata", wdata, m_wdata);
    chk("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'd0;
    model_reset();
    #3;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    #4 rst = 1'b1;

    // single long result drains on an idle pipe
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_0011);
    chk("r031_no_early_we", {31'd0, we}, 32'd0);
    idle();
    chk("r031_we", {31'd0, we}, 32'd1);
    chk("r031_waddr", {27'd0, waddr}, 32'd5);
    chk("r031_wdata", wdata, 32'h11);
    idle();

    // pipeline hogs the port; buffer fills and starvation raises stall
    step(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h2222);
    step(1'b1, 5'd1, 32'h101, 1'b1, 5'd3, 32'h3333);
    chk("r032_full", {31'd0, lu_ready}, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 5'd1, 32'h200 + i, 1'b0, 5'd0, 32'd0);
    chk("r032_stall", {31'd0, stall_req}, 32'd1);
    idle();
    chk("r032_first_r2", {27'd0, waddr}, 32'd2);
    idle();
    chk("r032_then_r3", {27'd0, waddr}, 32'd3);
    chk("r032_then_r3_data", wdata, 32'h3333);
    idle();

    // WAW kill of a buffered r7
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h7777);
    step(1'b1, 5'd7, 32'hAAAA_AAAA, 1'b0, 5'd0, 32'd0);
    chk("r033_wdata", wdata, 32'hAAAA_AAAA);
    idle();
    chk("r033_killed", {31'd0, we}, 32'd0);
    chk("r033_stall", {31'd0, stall_req}, 32'd0);

    // r0 writes from both sources are dropped
    step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    chk("r034_we", {31'd0, we}, 32'd0);
    idle();
    chk("r034_empty", {31'd0, we}, 32'd0);

    // simultaneous push and pop on a single-entry FIFO
    step(1'b1, 5'd1, 32'h5, 1'b1, 5'd4, 32'h4444);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6666);
    chk("r035_head", {27'd0, waddr}, 32'd4);
    chk("r035_ready", {31'd0, lu_ready}, 32'd1);
    idle();
    chk("r035_new", {27'd0, waddr}, 32'd6);
    idle();

    // asynchronous reset with two entries buffered
    step(1'b1, 5'd1, 32'h9, 1'b1, 5'd2, 32'h22);
    step(1'b1, 5'd1, 32'hA, 1'b1, 5'd3, 32'h33);
    @(negedge clk);
    pipe_we = 1'b0; lu_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("r036_we", {31'd0, we}, 32'd0);
    chk("r036_waddr", {27'd0, waddr}, 32'd0);
    chk("r036_wdata", wdata, 32'd0);
    chk("r036_ready", {31'd0, lu_ready}, 32'd1);
    model_reset();
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("r036_no_write", {31'd0, we}, 32'd0);
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 4; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
